// File: rtl/sample_capture_fifo.sv
// Triggered, decimating sample capture into a first-word-fall-through FIFO.
// Provides a valid/ready read port, occupancy level, done and a sticky overrun flag.
module sample_capture_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       s_data,
   input  logic                   s_valid,
   input  logic                   arm,
   input  logic                   trig_en,
   input  logic [WIDTH-1:0]       trig_value,
   input  logic [3:0]             decim,
   input  logic [7:0]             cap_len,
   output logic [WIDTH-1:0]       m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic [1:0]             state,
   output logic                   done,
   output logic                   overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_trig_en;
   logic [WIDTH-1:0] r_trig_value;
   logic [3:0]       r_decim;
   logic [7:0]       r_cap_len;
   logic [3:0]       r_dec_cnt;
   logic [7:0]       r_cap_cnt;
   logic             r_overrun;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;

   logic       w_trigger;
   logic       w_arm_ok;
   logic       w_take;
   logic       w_full;
   logic       w_wr;
   logic       w_rd;
   logic [7:0] w_cap_next;

   assign w_trigger  = s_valid && (!r_trig_en || (s_data == r_trig_value));
   assign w_arm_ok   = arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_full     = (r_level == LVL_FULL);
   assign w_cap_next = r_cap_cnt + 8'd1;

   // A decimated sample is "taken" even when full; the drop only suppresses the write.
   assign w_take = ((r_state == ST_ARMED) && w_trigger && (r_cap_len != 8'd0)) ||
                   ((r_state == ST_CAPTURE) && s_valid && (r_dec_cnt == 4'd0));
   assign w_wr   = w_take && !w_full;
   assign w_rd   = (r_level != '0) && m_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_trig_en    <= 1'b0;
         r_trig_value <= '0;
         r_decim      <= 4'd0;
         r_cap_len    <= 8'd0;
         r_dec_cnt    <= 4'd0;
         r_cap_cnt    <= 8'd0;
         r_overrun    <= 1'b0;
      end else if (w_arm_ok) begin
         r_trig_en    <= trig_en;
         r_trig_value <= trig_value;
         r_decim      <= decim;
         r_cap_len    <= cap_len;
         r_dec_cnt    <= 4'd0;
         r_cap_cnt    <= 8'd0;
         r_overrun    <= 1'b0;
         r_state      <= ST_ARMED;
      end else begin
         if (w_take && w_full)
            r_overrun <= 1'b1;
         case (r_state)
            ST_ARMED: begin
               if (w_trigger) begin
                  if (r_cap_len == 8'd0) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_cap_cnt <= 8'd1;
                     r_dec_cnt <= (r_decim == 4'd0) ? 4'd0 : 4'd1;
                     r_state   <= (r_cap_len == 8'd1) ? ST_DONE : ST_CAPTURE;
                  end
               end
            end
            ST_CAPTURE: begin
               if (s_valid) begin
                  r_dec_cnt <= (r_dec_cnt == r_decim) ? 4'd0 : r_dec_cnt + 4'd1;
                  if (r_dec_cnt == 4'd0) begin
                     r_cap_cnt <= w_cap_next;
                     if (w_cap_next == r_cap_len)
                        r_state <= ST_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_arm_ok) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd)
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + LVL_ONE;
            2'b01:   r_level <= r_level - LVL_ONE;
            default: ;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; emptiness is tracked by r_level and m_data is masked.
   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= s_data;
   end

   assign m_valid = (r_level != '0);
   assign m_data  = m_valid ? r_mem[r_rd_ptr] : '0;
   assign level   = r_level;
   assign state   = r_state;
   assign done    = (r_state == ST_DONE);
   assign overrun = r_overrun;

endmodule

// File: tb/tb_sample_capture_fifo.sv
// Bench for sample_capture_fifo: directed test-plan steps then random traffic,
// all checked against a queue-based reference model of the capture rules.
module tb_sample_capture_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic             arm;
   logic             trig_en;
   logic [WIDTH-1:0] trig_value;
   logic [3:0]       decim;
   logic [7:0]       cap_len;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic [LW-1:0]    level;
   logic [1:0]       state;
   logic             done;
   logic             overrun;

   always #5 clk = ~clk;

   sample_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .arm(arm),
      .trig_en(trig_en), .trig_value(trig_value), .decim(decim), .cap_len(cap_len),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
      .state(state), .done(done), .overrun(overrun)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: phase 0 idle, 1 armed, 2 capture, 3 done; idx counts valid samples since trigger.
   int               md_phase = 0;
   logic [WIDTH-1:0] md_q[$];
   bit               md_ov = 0;
   bit               l_ten = 0;
   logic [WIDTH-1:0] l_tval = '0;
   int               l_dec = 0;
   int               l_clen = 0;
   int               idx = 0;
   int               ncap = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit full;
      bit cap;
      if (reset) begin
         md_phase = 0; md_q.delete(); md_ov = 0;
         return;
      end
      if (arm && (md_phase == 0 || md_phase == 3)) begin
         l_ten = trig_en; l_tval = trig_value; l_dec = int'(decim); l_clen = int'(cap_len);
         md_q.delete(); md_ov = 0; md_phase = 1; idx = 0; ncap = 0;
         return;
      end
      full = (md_q.size() == DEPTH);
      cap  = 0;
      if (md_phase == 1 && s_valid && (!l_ten || s_data == l_tval)) begin
         if (l_clen == 0) md_phase = 3;
         else begin
            cap = 1; ncap = 1; idx = 1;
            md_phase = (l_clen == 1) ? 3 : 2;
         end
      end else if (md_phase == 2 && s_valid) begin
         if (idx % (l_dec + 1) == 0) begin
            cap = 1; ncap++;
            if (ncap == l_clen) md_phase = 3;
         end
         idx++;
      end
      if (m_ready && md_q.size() != 0) void'(md_q.pop_front());
      if (cap) begin
         if (full) md_ov = 1;
         else md_q.push_back(s_data);
      end
   endtask

   task automatic compare_all();
      check("state",   32'(state),   32'(md_phase));
      check("done",    32'(done),    32'(md_phase == 3));
      check("level",   32'(level),   32'(md_q.size()));
      check("m_valid", 32'(m_valid), 32'(md_q.size() != 0));
      check("m_data",  32'(m_data),  (md_q.size() != 0) ? 32'(md_q[0]) : 32'd0);
      check("overrun", 32'(overrun), 32'(md_ov));
   endtask

   task automatic cycle(input logic v, input logic [7:0] d, input logic rd);
      s_valid = v; s_data = d; m_ready = rd;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      arm = 1'b0; reset = 1'b0;
   endtask

   // Config inputs are scrambled after arming so any failure to latch shows up.
   task automatic do_arm(input logic te, input logic [7:0] tv, input logic [3:0] dc, input logic [7:0] cl);
      trig_en = te; trig_value = tv; decim = dc; cap_len = cl; arm = 1'b1;
      cycle(1'b0, 8'd0, 1'b0);
      trig_en = ~te; trig_value = ~tv; decim = ~dc; cap_len = ~cl;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b1);
   endtask

   logic [7:0] seq [5] = '{8'd1, 8'd3, 8'd13, 8'd183, 8'd137};

   initial begin
      reset = 1'b1; arm = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      trig_en = 1'b0; trig_value = '0; decim = '0; cap_len = '0;
      cycle(1'b0, 8'd0, 1'b0);
      check("rst_level", 32'(level), 32'd0);

      // Immediate trigger, no decimation, four samples.
      do_arm(1'b0, 8'd0, 4'd0, 8'd4);
      for (int i = 0; i < 5; i++) cycle(1'b1, seq[i], 1'b0);
      check("t1_level", 32'(level), 32'd4);
      check("t1_done", 32'(done), 32'd1);
      check("t1_head", 32'(m_data), 32'd1);
      drain(5);
      check("t1_empty", 32'(m_valid), 32'd0);

      // Trigger on value 13.
      do_arm(1'b1, 8'd13, 4'd0, 8'd2);
      cycle(1'b1, seq[0], 1'b0);
      check("t2_armed0", 32'(state), 32'd1);
      cycle(1'b1, seq[1], 1'b0);
      check("t2_armed1", 32'(state), 32'd1);
      for (int i = 2; i < 5; i++) cycle(1'b1, seq[i], 1'b0);
      check("t2_level", 32'(level), 32'd2);
      check("t2_head", 32'(m_data), 32'd13);
      drain(3);

      // Decimate by two.
      do_arm(1'b0, 8'd0, 4'd1, 8'd3);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 8'(i), 1'b0);
         if (i == 3) check("t3_not_done", 32'(done), 32'd0);
         if (i == 4) check("t3_done", 32'(done), 32'd1);
      end
      drain(4);

      // Overrun with no reads.
      do_arm(1'b0, 8'd0, 4'd0, 8'd20);
      for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), 1'b0);
      check("t4_level", 32'(level), 32'd16);
      check("t4_ovr", 32'(overrun), 32'd1);
      check("t4_done", 32'(done), 32'd1);
      do_arm(1'b0, 8'd0, 4'd0, 8'd5);
      check("t4_ovr_clr", 32'(overrun), 32'd0);
      check("t4_lvl_clr", 32'(level), 32'd0);

      // Reset mid-capture, then a normal capture.
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(40 + i), 1'b0);
      reset = 1'b1;
      cycle(1'b1, 8'd50, 1'b0);
      check("t5_state", 32'(state), 32'd0);
      check("t5_valid", 32'(m_valid), 32'd0);
      do_arm(1'b0, 8'd0, 4'd0, 8'd2);
      cycle(1'b1, 8'd9, 1'b0);
      cycle(1'b1, 8'd8, 1'b0);
      check("t5_done", 32'(done), 32'd1);
      drain(3);

      // Steady push+pop at level 5, then cap_len == 0.
      do_arm(1'b0, 8'd0, 4'd0, 8'd15);
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(100 + i), 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 8'(110 + i), 1'b1);
         check("t6_steady", 32'(level), 32'd5);
      end
      drain(6);
      do_arm(1'b0, 8'd0, 4'd0, 8'd0);
      cycle(1'b1, 8'd77, 1'b0);
      check("t6_zero_done", 32'(state), 32'd3);
      check("t6_zero_lvl", 32'(level), 32'd0);

      // Random traffic with occasional arm attempts and rare resets.
      for (int n = 0; n < 600; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         trig_en    = 1'($urandom_range(0, 1));
         trig_value = 8'($urandom_range(0, 15));
         decim      = 4'($urandom_range(0, 3));
         cap_len    = 8'($urandom_range(0, 40));
         if (r < 5) arm = 1'b1;
         if (r == 5) reset = 1'b1;
         cycle(1'($urandom_range(0, 9) < 7), 8'($urandom_range(0, 15)),
               1'($urandom_range(0, 9) < 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_capture_fifo.md
Name: sample_capture_fifo

Overview:
- Downstream consumer of the 8-bit sample stream produced by the sequence-generator stage.
- On `arm`, waits for an optional trigger value in the stream. It then decimates and captures a programmed number of samples into a DEPTH-entry FIFO.
- The FIFO is drained through a valid/ready read port for readout logic or external pins.
- Provides level, done and a sticky overrun flag, so the bench or host can tell whether the captured trace is complete.

Parameters:
- WIDTH, 8: sample width in bits.
- DEPTH, 16: FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_data  in  WIDTH  incoming sample.
- s_valid  in  1  s_data is valid this cycle; no backpressure, the stream never stalls.
- arm  in  1  single-cycle start request.
- trig_en  in  1  1 = wait for trig_value; 0 = trigger on first valid sample.
- trig_value  in  WIDTH  trigger match value.
- decim  in  4  keep one of every decim+1 valid samples.
- cap_len  in  8  number of decimated samples to capture (0..255).
- m_data  out  WIDTH  FIFO head data.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts head this cycle.
- level  out  log2(DEPTH)+1  current FIFO occupancy.
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- done  out  1  high in DONE.
- overrun  out  1  sticky: a decimated sample was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state = IDLE; FIFO emptied.
  - m_valid = 0, m_data = 0, level = 0, done = 0, overrun = 0.
  - Internal decimation and capture counters = 0.
  - A reset mid-capture discards all captured data.
- Arming:
  - `arm` is honoured in IDLE or DONE only; it is ignored in ARMED and CAPTURE.
  - On `arm`: flush the FIFO, clear overrun, zero both counters, and latch trig_en, trig_value, decim and cap_len. The next state is ARMED.
  - Later changes to these inputs have no effect until the next `arm`.
- ARMED:
  - Trigger condition: s_valid && (!trig_en || s_data == latched trig_value).
  - With latched cap_len == 0, the trigger goes directly to DONE and nothing is written.
  - Otherwise the trigger goes to CAPTURE. The trigger sample itself is decimated sample #0: it is pushed, capture count becomes 1, and the decimation counter becomes 1 (wrapping to 0 if decim == 0).
  - If cap_len == 1, the trigger goes directly to DONE after the push.
- CAPTURE:
  - On each s_valid, if decim counter == 0 the sample is a decimated sample: push it and increment the capture count.
  - The decim counter increments on each s_valid and wraps to 0 after reaching the latched decim.
  - When the capture count reaches cap_len (on the cycle of the final decimated sample), the next state is DONE.
  - Samples with s_valid = 0 are ignored entirely.
- Overrun:
  - If a push occurs while level == DEPTH (evaluated before this cycle's pop), the sample is dropped and overrun is set.
  - A dropped sample still counts toward cap_len.
  - Push at full with a simultaneous pop: the push is still dropped, the pop is performed, and level decrements.
- FIFO:
  - Registered first-word-fall-through.
  - A sample pushed in cycle N appears at m_data/m_valid in cycle N+1. There is no same-cycle bypass.
  - A pop occurs when m_valid && m_ready; the next entry (or m_valid = 0) appears the following cycle.
  - A simultaneous push and pop with level in 1..DEPTH-1 leaves level unchanged.
  - m_ready while empty has no effect.
  - Reads are allowed in any state, including during capture and DONE.
  - The read and write pointers are log2(DEPTH) bits wide and wrap naturally.
- DONE: done = 1; the FIFO keeps its contents until popped, `arm` or reset.

Test Plan:
- Sequence-generator stream 1,3,13,183,137 (ui_in=1 from reset) with trig_en=0, decim=0, cap_len=4, m_ready=0 -> FIFO holds 1,3,13,183; level=4; done=1; overrun=0. Then m_ready=1 -> reads 1,3,13,183 on consecutive cycles, then m_valid=0.
- Same stream with trig_en=1, trig_value=13, cap_len=2 -> captures exactly 13,183; ARMED persists through samples 1 and 3.
- Ramp 0..9 with decim=1, cap_len=3, immediate trigger -> captures 0,2,4; DONE asserted the cycle after sample 4 is accepted.
- Ramp 0..19 with cap_len=20, m_ready=0, DEPTH=16 -> FIFO holds 0..15; level=16; overrun=1; done=1. A subsequent `arm` clears overrun and sets level=0.
- Reset asserted after 3 samples are pushed -> next cycle state=0, m_valid=0, level=0, done=0, overrun=0. A following arm/capture works normally.
- Steady capture with m_ready=1 and level=5 -> level stays 5 on every push+pop cycle. With cap_len=0 and arm, the first valid sample produces DONE and level is unchanged at 0.
